// File: rtl/vid_pkg.sv
// vid_pkg: shared mode encodings, FSM state type and elaboration helpers
// for the video stream source.
package vid_pkg;

    localparam logic MODE_CONT   = 1'b0;
    localparam logic MODE_SINGLE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } vid_state_t;

    // Ceil log2, floored at 1 so a single-value range still gets one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int unsigned i = 0; i < 31; i++)
            if ((64'd1 << i) < 64'(value)) r = int'(i) + 1;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int h_total(input int sync, input int back, input int disp, input int front);
        return sync + back + disp + front;
    endfunction

    function automatic int v_total(input int sync, input int back, input int disp, input int front);
        return sync + back + disp + front;
    endfunction

endpackage

// File: rtl/vid_delay_line.sv
// vid_delay_line: DEPTH-stage shift register of WIDTH bits, async active-low reset to 0.
module vid_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [DEPTH*WIDTH-1:0] r_sr;

    if (DEPTH == 1) begin : g_one
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_sr <= '0;
            else        r_sr <= i_d;
        end
    end else begin : g_multi
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_sr <= '0;
            else        r_sr <= {r_sr[(DEPTH-1)*WIDTH-1:0], i_d};
        end
    end

    assign o_q = r_sr[DEPTH*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/vid_stream_src.sv
// vid_stream_src: vsync/href timing generator with fixed-latency frame-memory fetch of
// NCH pixel channels. Define VID_TPG_EN to add the tpg_sel test-pattern input.
module vid_stream_src
    import vid_pkg::*;
#(
    parameter int H_DISP  = 640,
    parameter int V_DISP  = 480,
    parameter int H_SYNC  = 5,
    parameter int H_BACK  = 5,
    parameter int H_FRONT = 5,
    parameter int V_SYNC  = 1,
    parameter int V_BACK  = 0,
    parameter int V_FRONT = 1,
    parameter int NCH     = 2,
    parameter int PIX_W   = 24,
    parameter int ADDR_W  = 20,
    parameter int RD_LAT  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      mode,
`ifdef VID_TPG_EN
    input  logic                      tpg_sel,
`endif
    output logic                      rd_en,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic [NCH*PIX_W-1:0]      rd_data,
    output logic                      vsync,
    output logic                      href,
    output logic                      clken,
    output logic [clog2(H_DISP)-1:0]  pix_x,
    output logic [clog2(V_DISP)-1:0]  pix_y,
    output logic [NCH*PIX_W-1:0]      pix_data,
    output logic                      busy,
    output logic                      frame_done,
    output logic [15:0]               frame_cnt
);

    localparam int H_TOT = h_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
    localparam int V_TOT = v_total(V_SYNC, V_BACK, V_DISP, V_FRONT);
    localparam int HW    = clog2(H_TOT);
    localparam int VW    = clog2(V_TOT);
    localparam int XW    = clog2(H_DISP);
    localparam int YW    = clog2(V_DISP);
    localparam int HOFF  = H_SYNC + H_BACK;
    localparam int VOFF  = V_SYNC + V_BACK;
    localparam int DW    = clog2(RD_LAT + 3);
    localparam int DL_W  = 2 + XW + YW;
`ifdef VID_TPG_EN
    localparam int TAG_W = 1 + XW + YW;
`else
    localparam int TAG_W = 1;
`endif

    vid_state_t            r_state;
    logic [HW-1:0]         r_hcnt;
    logic [VW-1:0]         r_vcnt;
    logic [DW-1:0]         r_drain;
    logic                  r_mode;
    logic                  r_stop_pend;
    logic                  r_rd_en;
    logic [ADDR_W-1:0]     r_rd_addr;
    logic [NCH*PIX_W-1:0]  r_pix_data;
    logic                  r_frame_done;
    logic [15:0]           r_frame_cnt;

    logic                  w_run;
    logic                  w_eof;
    logic                  w_active;
    logic                  w_vs;
    logic                  w_rd_req;
    logic                  w_last;
    logic [XW-1:0]         w_x;
    logic [YW-1:0]         w_y;
    logic [DL_W-1:0]       w_dl_q;
    logic [TAG_W-1:0]      w_tag_d;
    logic [TAG_W-1:0]      w_tag_q;
    logic [NCH*PIX_W-1:0]  w_src_data;

    // Timing inputs are gated by RUN, so DRAIN shifts zeros in and the outputs idle low.
    assign w_run    = (r_state == ST_RUN);
    assign w_eof    = (r_hcnt == HW'(H_TOT - 1)) && (r_vcnt == VW'(V_TOT - 1));
    assign w_active = w_run
                   && (int'(r_hcnt) >= HOFF) && (int'(r_hcnt) < HOFF + H_DISP)
                   && (int'(r_vcnt) >= VOFF) && (int'(r_vcnt) < VOFF + V_DISP);
    assign w_vs     = w_run && (int'(r_vcnt) >= V_SYNC);
    assign w_x      = w_active ? XW'(int'(r_hcnt) - HOFF) : '0;
    assign w_y      = w_active ? YW'(int'(r_vcnt) - VOFF) : '0;

`ifdef VID_TPG_EN
    logic                  r_tpg;
    logic [PIX_W-1:0]      w_pat;
    assign w_rd_req   = w_active && !r_tpg;
    assign w_tag_d    = {w_active, w_x, w_y};
    assign w_pat      = PIX_W'({8'(w_tag_q[YW +: XW]), 8'(w_tag_q[0 +: YW]), r_frame_cnt[7:0]});
    assign w_src_data = r_tpg ? {NCH{w_pat}} : rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         r_tpg <= 1'b0;
        else if (r_state == ST_IDLE && start) r_tpg <= tpg_sel;
    end
`else
    assign w_rd_req   = w_active;
    assign w_tag_d    = w_active;
    assign w_src_data = rd_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_drain     <= '0;
            r_mode      <= MODE_CONT;
            r_stop_pend <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_RUN;
                        r_mode      <= mode;
                        r_hcnt      <= '0;
                        r_vcnt      <= '0;
                        r_stop_pend <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (stop) r_stop_pend <= 1'b1;
                    if (w_eof && (r_mode == MODE_SINGLE || r_stop_pend || stop)) begin
                        r_state <= ST_DRAIN;
                        r_drain <= '0;
                    end else if (r_hcnt == HW'(H_TOT - 1)) begin
                        r_hcnt <= '0;
                        r_vcnt <= (r_vcnt == VW'(V_TOT - 1)) ? '0 : r_vcnt + VW'(1);
                    end else begin
                        r_hcnt <= r_hcnt + HW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == DW'(RD_LAT + 1)) begin
                        r_state     <= ST_IDLE;
                        r_stop_pend <= 1'b0;
                    end else begin
                        r_drain <= r_drain + DW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            r_rd_en   <= w_rd_req;
            r_rd_addr <= ADDR_W'(int'(w_y) * H_DISP + int'(w_x));
        end
    end

    vid_delay_line #(.WIDTH(DL_W), .DEPTH(RD_LAT + 2)) u_timing_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   ({w_vs, w_active, w_x, w_y}),
        .o_q   (w_dl_q)
    );

    // Tag arrives with rd_data so the output register can blank/pattern in the same edge as href.
    vid_delay_line #(.WIDTH(TAG_W), .DEPTH(RD_LAT + 1)) u_tag_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (w_tag_d),
        .o_q   (w_tag_q)
    );

    assign w_last = href && (pix_y == YW'(V_DISP - 1)) && (pix_x == XW'(H_DISP - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_data   <= '0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_pix_data   <= w_tag_q[TAG_W-1] ? w_src_data : '0;
            r_frame_done <= w_last;
            if (w_last) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign vsync      = w_dl_q[DL_W-1];
    assign href       = w_dl_q[DL_W-2];
    assign pix_x      = w_dl_q[YW +: XW];
    assign pix_y      = w_dl_q[0 +: YW];
    assign clken      = href;
    assign rd_en      = r_rd_en;
    assign rd_addr    = r_rd_addr;
    assign pix_data   = r_pix_data;
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = r_frame_done;
    assign frame_cnt  = r_frame_cnt;

endmodule
